// File: rtl/pipe_pkg.sv
// Purpose : shared encodings for the instruction-fetch stage (pcsrc select
//           codes, the NOP/bubble word, FSM state type and encodings) and a
//           small helper for the sequential pc+4 increment.
// Contents: PCSRC_* constants, NOP, if_state_t, S_RESET/S_FETCH/S_HOLD, pc_plus4().
package pipe_pkg;

    // Next-pc select codes driven by the decode stage.
    localparam logic [1:0] PCSRC_SEQ = 2'b00;  // pc + 4
    localparam logic [1:0] PCSRC_BR  = 2'b01;  // branch target
    localparam logic [1:0] PCSRC_REG = 2'b10;  // register-jump target
    localparam logic [1:0] PCSRC_JMP = 2'b11;  // jump target

    // Word loaded into IF/ID when no instruction is available (a bubble).
    localparam logic [31:0] NOP = 32'h0000_0000;

    // Fetch FSM state type and its encodings.
    typedef logic [1:0] if_state_t;
    localparam if_state_t S_RESET = 2'd0;
    localparam if_state_t S_FETCH = 2'd1;
    localparam if_state_t S_HOLD  = 2'd2;

    // Sequential successor of a fetch address; wraps modulo 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pipe_if_npc.sv
// Purpose : combinational next-pc selection for the fetch stage, including
//           the pc+4 adder and the pending-redirect override.
// Ports   : pc_i/pcsrc_i/bpc_i/rpc_i/jpc_i in; redirect_valid_i/redirect_pc_i in;
//           pc4_o (pc+4), target_o (pcsrc-selected address), npc_o (final next pc).
module pipe_if_npc
    import pipe_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [1:0]  pcsrc_i,
    input  logic [31:0] bpc_i,
    input  logic [31:0] rpc_i,
    input  logic [31:0] jpc_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc4_o,
    output logic [31:0] target_o,
    output logic [31:0] npc_o
);

    assign pc4_o = pc_plus4(pc_i);

    always_comb begin
        target_o = pc4_o;
        case (pcsrc_i)
            PCSRC_BR:  target_o = bpc_i;
            PCSRC_REG: target_o = rpc_i;
            PCSRC_JMP: target_o = jpc_i;
            default:   target_o = pc4_o;
        endcase
    end

    // A redirect captured while the delay-slot fetch was still outstanding
    // takes priority over whatever decode is presenting now: by then decode
    // may have moved past the control-transfer instruction.
    assign npc_o = redirect_valid_i ? redirect_pc_i : target_o;

endmodule

// File: rtl/pipe_if_stage.sv
// Purpose : instruction-fetch stage; issues one fetch at a time to instruction
//           memory and fills the IF/ID register (dpc4, inst, ivalid).
// Ports   : clk/rst (sync, active-high); pcsrc/bpc/rpc/jpc/nostall from decode;
//           imem_req/imem_addr out, imem_ack/imem_rdata in; pc, dpc4, inst, ivalid out.
// Option  : define PIPE_IF_BUBBLE_CNT_EN to add the 32-bit bubble_cnt output.
//
// Latency: an acked fetch lands in IF/ID on the next edge when decode accepts;
// back-to-back acks sustain one instruction per cycle. When decode stalls on
// an ack the word is parked in a hold buffer and the memory request is dropped
// until decode takes it.
module pipe_if_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pcsrc,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    input  logic        nostall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] dpc4,
    output logic [31:0] inst,
    output logic        ivalid
`ifdef PIPE_IF_BUBBLE_CNT_EN
    ,
    output logic [31:0] bubble_cnt
`endif
);

    if_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] dpc4_q, dpc4_d;
    logic [31:0] inst_q, inst_d;
    logic        ivalid_q, ivalid_d;
    logic        rv_q, rv_d;          // redirect pending
    logic [31:0] rpc_q, rpc_d;        // redirect target
    logic [31:0] hold_q, hold_d;      // word parked while decode stalls

    logic [31:0] pc4;
    logic [31:0] target;
    logic [31:0] npc;

    pipe_if_npc u_npc (
        .pc_i             (pc_q),
        .pcsrc_i          (pcsrc),
        .bpc_i            (bpc),
        .rpc_i            (rpc),
        .jpc_i            (jpc),
        .redirect_valid_i (rv_q),
        .redirect_pc_i    (rpc_q),
        .pc4_o            (pc4),
        .target_o         (target),
        .npc_o            (npc)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        dpc4_d   = dpc4_q;
        inst_d   = inst_q;
        ivalid_d = ivalid_q;
        rv_d     = rv_q;
        rpc_d    = rpc_q;
        hold_d   = hold_q;

        case (state_q)
            S_RESET: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                if (imem_ack && nostall) begin
                    // Issue straight into IF/ID and keep fetching next cycle.
                    pc_d     = npc;
                    dpc4_d   = pc4;
                    inst_d   = imem_rdata;
                    ivalid_d = 1'b1;
                    rv_d     = 1'b0;
                end else if (imem_ack) begin
                    hold_d  = imem_rdata;
                    state_d = S_HOLD;
                end else if (nostall) begin
                    // Decode wants an instruction but memory has none yet:
                    // hand it a bubble. pc stays put so the outstanding
                    // (delay-slot) fetch completes first; a control transfer
                    // seen now is remembered and applied when pc advances.
                    inst_d   = NOP;
                    ivalid_d = 1'b0;
                    if (pcsrc != PCSRC_SEQ) begin
                        rv_d  = 1'b1;
                        rpc_d = target;
                    end
                end
            end

            S_HOLD: begin
                if (nostall) begin
                    pc_d     = npc;
                    dpc4_d   = pc4;
                    inst_d   = hold_q;
                    ivalid_d = 1'b1;
                    rv_d     = 1'b0;
                    state_d  = S_FETCH;
                end
            end

            default: begin
                // Unused encoding: restart cleanly.
                state_d = S_RESET;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_RESET;
            pc_q     <= RESET_PC;
            dpc4_q   <= 32'h0;
            inst_q   <= NOP;
            ivalid_q <= 1'b0;
            rv_q     <= 1'b0;
            rpc_q    <= 32'h0;
            hold_q   <= 32'h0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            dpc4_q   <= dpc4_d;
            inst_q   <= inst_d;
            ivalid_q <= ivalid_d;
            rv_q     <= rv_d;
            rpc_q    <= rpc_d;
            hold_q   <= hold_d;
        end
    end

    // The request is a pure function of state and pc, so it stays stable
    // until the ack that moves either of them.
    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign dpc4      = dpc4_q;
    assign inst      = inst_q;
    assign ivalid    = ivalid_q;

`ifdef PIPE_IF_BUBBLE_CNT_EN
    logic [31:0] bcnt_q;
    logic        bubble_ins;

    assign bubble_ins = (state_q == S_FETCH) && !imem_ack && nostall;

    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt_q <= 32'h0;
        end else if (bubble_ins) begin
            bcnt_q <= bcnt_q + 32'd1;
        end
    end

    assign bubble_cnt = bcnt_q;
`endif

`ifndef SYNTHESIS
    // An un-acked request must be presented unchanged on the next cycle.
    a_req_stable : assert property (@(posedge clk) disable iff (rst)
        (imem_req && !imem_ack) |=> (imem_req && $stable(imem_addr)));
`endif

endmodule

// File: tb/tb_pipe_if_stage.sv
// Purpose : self-checking bench for pipe_if_stage: directed scenarios with
//           literal expectations, then randomized traffic against a model.
// Ports   : none (top-level bench); drives the DUT on negedges, checks on negedges.
module tb_pipe_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pcsrc;
    logic [31:0] bpc, rpc, jpc;
    logic        nostall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc, dpc4, inst;
    logic        ivalid;
`ifdef PIPE_IF_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Instruction memory contents are a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    pipe_if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .pcsrc      (pcsrc),
        .bpc        (bpc),
        .rpc        (rpc),
        .jpc        (jpc),
        .nostall    (nostall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .dpc4       (dpc4),
        .inst       (inst),
        .ivalid     (ivalid)
`ifdef PIPE_IF_BUBBLE_CNT_EN
        ,
        .bubble_cnt (bubble_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Tracks what the stage must present: whether it is in its post-reset
    // cycle, fetching, or sitting on a parked word; the fetch address; the
    // IF/ID contents; any remembered jump target; and the bubble count.
    bit          m_started = 1'b0;
    bit          m_after_reset, m_parked;
    logic [31:0] m_pc, m_dpc4, m_inst, m_parked_word, m_jump_to;
    bit          m_ivalid, m_jump_pending;
    logic [31:0] m_bubbles;

    function automatic logic [31:0] chosen_target(input logic [31:0] cur);
        case (pcsrc)
            2'b01:   return bpc;
            2'b10:   return rpc;
            2'b11:   return jpc;
            default: return cur + 32'd4;
        endcase
    endfunction

    task automatic model_issue(input logic [31:0] word);
        logic [31:0] nxt;
        nxt            = m_jump_pending ? m_jump_to : chosen_target(m_pc);
        m_dpc4         = m_pc + 32'd4;
        m_inst         = word;
        m_ivalid       = 1'b1;
        m_jump_pending = 1'b0;
        m_pc           = nxt;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_started      = 1'b1;
            m_after_reset  = 1'b1;
            m_parked       = 1'b0;
            m_pc           = 32'h0;
            m_dpc4         = 32'h0;
            m_inst         = 32'h0;
            m_ivalid       = 1'b0;
            m_jump_pending = 1'b0;
            m_jump_to      = 32'h0;
            m_parked_word  = 32'h0;
            m_bubbles      = 32'h0;
        end else if (m_started) begin
            if (m_after_reset) begin
                m_after_reset = 1'b0;
            end else if (m_parked) begin
                if (nostall) begin
                    model_issue(m_parked_word);
                    m_parked = 1'b0;
                end
            end else if (imem_ack && nostall) begin
                model_issue(mem_word(m_pc));
            end else if (imem_ack) begin
                m_parked_word = mem_word(m_pc);
                m_parked      = 1'b1;
            end else if (nostall) begin
                m_inst    = 32'h0;
                m_ivalid  = 1'b0;
                m_bubbles = m_bubbles + 32'd1;
                if (pcsrc != 2'b00) begin
                    m_jump_pending = 1'b1;
                    m_jump_to      = chosen_target(m_pc);
                end
            end
        end
    end

    // Compare every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (m_started) begin
            chk("imem_req",  {31'h0, imem_req}, {31'h0, (!m_after_reset && !m_parked)});
            chk("imem_addr", imem_addr, m_pc);
            chk("pc",        pc, m_pc);
            chk("dpc4",      dpc4, m_dpc4);
            chk("inst",      inst, m_inst);
            chk("ivalid",    {31'h0, ivalid}, {31'h0, m_ivalid});
`ifdef PIPE_IF_BUBBLE_CNT_EN
            chk("bubble_cnt", bubble_cnt, m_bubbles);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic r, input logic ack, input logic ns,
                        input logic [1:0] ps, input logic [31:0] b, input logic [31:0] j);
        rst      = r;
        imem_ack = ack;
        nostall  = ns;
        pcsrc    = ps;
        bpc      = b;
        jpc      = j;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic        r, a, ns;
        logic [1:0]  ps;
        logic [31:0] b, j;

        rst = 1'b1; imem_ack = 1'b0; nostall = 1'b0; pcsrc = 2'b00;
        bpc = 32'h0; rpc = 32'h0; jpc = 32'h0;

        // Reset state.
        step(1, 0, 0, 2'b00, 0, 0);
        step(1, 1, 1, 2'b00, 0, 0);
        chk("rst_pc",     pc, 32'h0);
        chk("rst_req",    {31'h0, imem_req}, 32'h0);
        chk("rst_ivalid", {31'h0, ivalid}, 32'h0);
        chk("rst_inst",   inst, 32'h0);
        chk("rst_dpc4",   dpc4, 32'h0);

        // Streaming: ack and nostall every cycle.
        step(0, 1, 1, 2'b00, 0, 0);
        chk("first_req",  {31'h0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            step(0, 1, 1, 2'b00, 0, 0);
            chk("stream_addr",   imem_addr, 32'(4 * k));
            chk("stream_inst",   inst, mem_word(32'(4 * (k - 1))));
            chk("stream_dpc4",   dpc4, 32'(4 * k));
            chk("stream_ivalid", {31'h0, ivalid}, 32'h1);
        end
        chk("model_pc_0x20", m_pc, 32'h0000_0020);

        // Branch seen while the delay-slot fetch at 0x20 is pending.
        step(0, 0, 1, 2'b01, 32'h0000_0100, 0);
        chk("dslot_bubble", {31'h0, ivalid}, 32'h0);
        chk("dslot_addr",   imem_addr, 32'h0000_0020);
        step(0, 1, 1, 2'b00, 0, 0);
        chk("dslot_inst",   inst, mem_word(32'h0000_0020));
        chk("dslot_dpc4",   dpc4, 32'h0000_0024);
        chk("redir_addr",   imem_addr, 32'h0000_0100);

        // Ack delayed three cycles from a fresh reset.
        step(1, 0, 0, 2'b00, 0, 0);
        step(0, 0, 0, 2'b00, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 2'b00, 0, 0);
            chk("wait_ivalid", {31'h0, ivalid}, 32'h0);
            chk("wait_inst",   inst, 32'h0);
            chk("wait_pc",     pc, 32'h0);
        end
`ifdef PIPE_IF_BUBBLE_CNT_EN
        chk("bubble_cnt_3", bubble_cnt, 32'd3);
`endif
        chk("model_bubbles_3", m_bubbles, 32'd3);
        step(0, 1, 1, 2'b00, 0, 0);
        chk("late_inst", inst, mem_word(32'h0));
        chk("late_pc",   pc, 32'h4);

        // Decode stalls on an ack for two cycles.
        step(0, 1, 0, 2'b00, 0, 0);
        chk("hold_req",  {31'h0, imem_req}, 32'h0);
        chk("hold_inst", inst, mem_word(32'h0));
        step(0, 1, 0, 2'b00, 0, 0);
        chk("hold_req2", {31'h0, imem_req}, 32'h0);
        chk("hold_pc",   pc, 32'h4);
        step(0, 0, 1, 2'b00, 0, 0);
        chk("unhold_inst", inst, mem_word(32'h4));
        chk("unhold_dpc4", dpc4, 32'h8);
        chk("unhold_req",  {31'h0, imem_req}, 32'h1);

        // pc+4 wraps at the top of the address space.
        step(0, 1, 1, 2'b11, 0, 32'hFFFF_FFFC);
        chk("jump_top", pc, 32'hFFFF_FFFC);
        step(0, 1, 1, 2'b00, 0, 0);
        chk("wrap_pc",   pc, 32'h0);
        chk("wrap_dpc4", dpc4, 32'h0);
        chk("wrap_inst", inst, mem_word(32'hFFFF_FFFC));

        // Reset during a wait with a late ack.
        step(0, 1, 1, 2'b00, 0, 0);
        step(0, 1, 1, 2'b00, 0, 0);
        step(0, 0, 1, 2'b00, 0, 0);
        step(1, 1, 1, 2'b00, 0, 0);
        chk("midrst_pc",     pc, 32'h0);
        chk("midrst_ivalid", {31'h0, ivalid}, 32'h0);
        step(0, 1, 1, 2'b00, 0, 0);
        chk("postrst_ivalid", {31'h0, ivalid}, 32'h0);
        chk("postrst_addr",   imem_addr, 32'h0);
        step(0, 1, 1, 2'b00, 0, 0);
        chk("postrst_inst", inst, mem_word(32'h0));
        chk("postrst_pc",   pc, 32'h4);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 199) == 0);
            a   = ($urandom_range(0, 9) < 6);
            ns  = ($urandom_range(0, 9) < 7);
            ps  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            b   = $urandom & 32'hFFFF_FFFC;
            j   = $urandom & 32'hFFFF_FFFC;
            rpc = $urandom & 32'hFFFF_FFFC;
            step(r, a, ns, ps, b, j);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_if_stage.md
PIPE_IF_STAGE -- requirements
Module: pipe_if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have one clock and a synchronous active-high reset: clk is the single clock and rst is the reset.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port pcsrc, input, 2 bits: next-pc select from ID; 00 = pc+4, 01 = bpc, 10 = rpc, 11 = jpc.
REQ-006 SHALL have ports bpc, rpc and jpc, each input, 32 bits: branch target, register-jump target (ID operand a) and jump target.
REQ-007 SHALL have port nostall, input, 1 bit: ID accepts a new instruction this cycle.
REQ-008 SHALL have port imem_req, output, 1 bit, and port imem_addr, output, 32 bits: fetch request and word address.
REQ-009 SHALL have port imem_ack, input, 1 bit, and port imem_rdata, input, 32 bits: fetch complete and instruction word, both valid in the same cycle.
REQ-010 SHALL have port pc, output, 32 bits: current fetch PC.
REQ-011 SHALL have ports dpc4 and inst, each output, 32 bits: IF/ID register contents (pc+4 and instruction).
REQ-012 SHALL have port ivalid, output, 1 bit: IF/ID holds a real instruction; 0 means a bubble.

Function
REQ-013 SHALL implement FSM states S_RESET, S_FETCH and S_HOLD; S_RESET always goes to S_FETCH on the next cycle.
REQ-014 SHALL drive imem_req=1 only in S_FETCH, with imem_addr=pc, and SHALL hold both stable until imem_ack.
REQ-015 SHALL compute npc = redirect_pc when redirect_valid=1; otherwise npc SHALL follow pcsrc, with pc+4 computed modulo 2^32 (0xFFFFFFFC+4 -> 0).
REQ-016 In S_FETCH, when imem_ack=1 and nostall=1, SHALL do all of: pc<=npc; dpc4<=pc+4; inst<=imem_rdata; ivalid<=1; redirect_valid<=0. The state SHALL stay S_FETCH (zero-bubble throughput).
REQ-017 In S_FETCH, when imem_ack=1 and nostall=0, SHALL capture imem_rdata in the hold buffer and go to S_HOLD; pc and IF/ID SHALL be unchanged.
REQ-018 In S_FETCH, when imem_ack=0 and nostall=1, SHALL load a bubble (inst=32'h0, ivalid=0, dpc4 unchanged) and SHALL keep pc unchanged.
REQ-019 In the REQ-018 case, when pcsrc!=00, SHALL set redirect_valid<=1 and redirect_pc<=selected target, so the delay-slot fetch completes before the jump.
REQ-020 When imem_ack=0 and nostall=0, SHALL change nothing.
REQ-021 In S_HOLD, SHALL keep imem_req=0; when nostall=1, SHALL load the hold buffer into IF/ID exactly as REQ-016 and go to S_FETCH; otherwise it SHALL wait.
REQ-022 SHALL never capture a redirect and consume one in the same cycle; a redirect is cleared only when pc advances.
REQ-023 SHALL ignore imem_ack outside S_FETCH.

Reset
REQ-024 While rst=1 at a clock edge, SHALL set: state=S_RESET, pc=RESET_PC, dpc4=0, inst=0, ivalid=0, redirect_valid=0, redirect_pc=0, hold buffer=0. imem_req SHALL be 0 in the following cycle.
REQ-025 Reset during S_FETCH or S_HOLD SHALL abandon the outstanding fetch, and any late imem_ack SHALL be ignored per REQ-023.

Configuration
REQ-026 With macro PIPE_IF_BUBBLE_CNT_EN defined, SHALL add output bubble_cnt (32 bits, reset 0) that increments by 1 per bubble inserted per REQ-018 and wraps at 2^32. Without the macro, the port and counter SHALL be absent.

Structure
REQ-027 Package pipe_pkg SHALL hold the pcsrc encodings, the NOP constant 32'h0 and the FSM state typedef.
REQ-028 Next-pc selection and the pc+4 adder SHALL live in combinational sub-module pipe_if_npc.

Verification
REQ-029 Reset, then imem_ack=1 every cycle and nostall=1: imem_addr SHALL go 0,4,8,...; inst SHALL equal imem_rdata one cycle after ack; ivalid SHALL be 1.
REQ-030 imem_ack delayed 3 cycles: 3 bubbles (inst=0, ivalid=0) SHALL appear, pc SHALL be steady, and bubble_cnt SHALL reach 3 when the macro is defined.
REQ-031 Ack with nostall=0 for 2 cycles: S_HOLD SHALL be entered, imem_req SHALL be 0, and the buffered inst SHALL issue on the first nostall=1 cycle.
REQ-032 pcsrc=01, bpc=0x100 while the delay-slot fetch is pending at 0x20: 0x20 SHALL complete first and the next imem_addr SHALL be 0x100.
REQ-033 pc=0xFFFFFFFC with pcsrc=00: next pc SHALL be 0x0.
REQ-034 rst asserted mid-wait with a late ack: the ack SHALL be ignored and fetch SHALL restart at RESET_PC.
